mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_arb.sv | 151 +++++++++++++++
 tb/tb_mem_arb.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the instruction/data memory arbiter.
//   arb_state_t : arbiter FSM state encoding
//   owner_t     : which requester owns the transaction in flight
//   FETCH_MASK  : byte mask driven for every instruction fetch
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic [3:0] FETCH_MASK = 4'b1111;

endpackage

// File: rtl/mem_arb.sv
// Two-port arbiter in front of a unified memory: one instruction-fetch port and
// one data (load/store) port share a single request/response channel. At most
// one transaction is outstanding. Data normally wins a conflict; after
// STARVE_LIMIT consecutive data grants with a fetch waiting, the fetch wins.
//
// Ports
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_if_valid/o_if_ready/i_if_addr fetch request channel
//   i_d_valid/o_d_ready/i_d_addr/
//   i_d_wen/i_d_wdata/i_d_mask      data request channel
//   o_mem_valid/i_mem_ready/
//   o_mem_addr/wen/wdata/mask       memory request channel
//   i_mem_rvalid/i_mem_rdata        memory read response
//   o_if_rvalid/o_d_rvalid/
//   o_rsp_rdata                     per-requester response pulses + data
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transaction in flight; requests may be granted
// ST_ISSUE | latched request presented to memory until i_mem_ready
// ST_WAIT  | load/fetch accepted by memory, waiting for i_mem_rvalid
module mem_arb
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_valid,
    output logic        o_if_ready,
    input  logic [31:0] i_if_addr,
    input  logic        i_d_valid,
    output logic        o_d_ready,
    input  logic [31:0] i_d_addr,
    input  logic        i_d_wen,
    input  logic [31:0] i_d_wdata,
    input  logic [3:0]  i_d_mask,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_if_rvalid,
    output logic        o_d_rvalid,
    output logic [31:0] o_rsp_rdata
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    arb_state_t    state;
    owner_t        owner;
    logic [CW-1:0] starve_cnt;
    logic          fetch_wins;
    logic          grant_if;
    logic          grant_d;

    // Grants are combinational so a lone requester is accepted in the same
    // cycle its valid is seen. Gating with i_rst_n keeps both ready outputs
    // low while reset is held, so the earliest possible grant is the first
    // rising edge after release.
    always_comb begin
        fetch_wins = i_if_valid && (!i_d_valid || (starve_cnt == STARVE_MAX));
        grant_if   = i_rst_n && (state == ST_IDLE) && fetch_wins;
        grant_d    = i_rst_n && (state == ST_IDLE) && i_d_valid && !fetch_wins;
    end

    assign o_if_ready = grant_if;
    assign o_d_ready  = grant_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            owner       <= OWN_IF;
            starve_cnt  <= '0;
            o_mem_valid <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wen   <= 1'b0;
            o_mem_wdata <= '0;
            o_mem_mask  <= '0;
            o_if_rvalid <= 1'b0;
            o_d_rvalid  <= 1'b0;
            o_rsp_rdata <= '0;
        end else begin
            // Response pulses last exactly one cycle.
            o_if_rvalid <= 1'b0;
            o_d_rvalid  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_if) begin
                        owner       <= OWN_IF;
                        o_mem_valid <= 1'b1;
                        o_mem_addr  <= i_if_addr;
                        o_mem_wen   <= 1'b0;
                        o_mem_wdata <= '0;
                        o_mem_mask  <= FETCH_MASK;
                        starve_cnt  <= '0;
                        state       <= ST_ISSUE;
                    end else if (grant_d) begin
                        owner       <= OWN_D;
                        o_mem_valid <= 1'b1;
                        o_mem_addr  <= i_d_addr;
                        o_mem_wen   <= i_d_wen;
                        o_mem_wdata <= i_d_wdata;
                        o_mem_mask  <= i_d_mask;
                        // Only count data wins that actually made a fetch wait.
                        if (i_if_valid && (starve_cnt != STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + CW'(1);
                        end
                        state       <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (i_mem_ready) begin
                        o_mem_valid <= 1'b0;
                        if (o_mem_wen) begin
                            // Stores complete on acceptance; no read data follows.
                            o_d_rvalid  <= 1'b1;
                            o_rsp_rdata <= '0;
                            state       <= ST_IDLE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (i_mem_rvalid) begin
                        o_rsp_rdata <= i_mem_rdata;
                        if (owner == OWN_IF) begin
                            o_if_rvalid <= 1'b1;
                        end else begin
                            o_d_rvalid <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_if_valid;
    logic        o_if_ready;
    logic [31:0] i_if_addr;
    logic        i_d_valid;
    logic        o_d_ready;
    logic [31:0] i_d_addr;
    logic        i_d_wen;
    logic [31:0] i_d_wdata;
    logic [3:0]  i_d_mask;
    logic        o_mem_valid;
    logic        i_mem_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_if_rvalid;
    logic        o_d_rvalid;
    logic [31:0] o_rsp_rdata;

    mem_arb #(.STARVE_LIMIT(2)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_if_valid   (i_if_valid),
        .o_if_ready   (o_if_ready),
        .i_if_addr    (i_if_addr),
        .i_d_valid    (i_d_valid),
        .o_d_ready    (o_d_ready),
        .i_d_addr     (i_d_addr),
        .i_d_wen      (i_d_wen),
        .i_d_wdata    (i_d_wdata),
        .i_d_mask     (i_d_mask),
        .o_mem_valid  (o_mem_valid),
        .i_mem_ready  (i_mem_ready),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wen    (o_mem_wen),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_mask   (o_mem_mask),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .o_if_rvalid  (o_if_rvalid),
        .o_d_rvalid   (o_d_rvalid),
        .o_rsp_rdata  (o_rsp_rdata)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } rsp_t;

    rsp_t rsp_q[$];

    // Memory model controls
    int          ready_delay = 0;
    bit          rsp_enable  = 1'b1;
    int          spur_req    = 0;
    int          spur_done   = 0;
    logic [31:0] spur_data   = 32'h0;
    bit          pend_rd     = 1'b0;
    logic [31:0] pend_addr   = 32'h0;
    int          wait_cnt    = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h0000_0013 : (a ^ 32'hC0DE_0000);
    endfunction

    // Memory model: ready after ready_delay cycles of valid, read data one
    // cycle after the handshake.
    initial begin : mem_model
        i_mem_ready  = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 32'h0;
        forever begin
            @(negedge i_clk);
            if (spur_req != spur_done) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = spur_data;
                spur_done    = spur_req;
            end else if (pend_rd && rsp_enable) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = mem_word(pend_addr);
                pend_rd      = 1'b0;
            end else begin
                i_mem_rvalid = 1'b0;
            end
            if (!o_mem_valid) begin
                i_mem_ready = 1'b0;
                wait_cnt    = 0;
            end else if (wait_cnt >= ready_delay) begin
                i_mem_ready = 1'b1;
                wait_cnt    = 0;
                if (!o_mem_wen) begin
                    pend_rd   = 1'b1;
                    pend_addr = o_mem_addr;
                end
            end else begin
                i_mem_ready = 1'b0;
                wait_cnt++;
            end
        end
    end

    // Response scoreboard
    initial begin : rsp_monitor
        rsp_t e;
        forever begin
            @(negedge i_clk);
            if (o_if_rvalid || o_d_rvalid) begin
                checks++;
                if (o_if_rvalid && o_d_rvalid) begin
                    errors++;
                    $display("FAIL rsp_both_rvalid: if_rvalid=%0b d_rvalid=%0b, required at most one", o_if_rvalid, o_d_rvalid);
                end else if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: if=%0b d=%0b data=%h at cycle %0d, required no response", o_if_rvalid, o_d_rvalid, o_rsp_rdata, cyc);
                end else begin
                    e = rsp_q.pop_front();
                    if (o_d_rvalid !== e.is_d || o_rsp_rdata !== e.data) begin
                        errors++;
                        $display("FAIL rsp_data: got d=%0b data=%h, required d=%0b data=%h", o_d_rvalid, o_rsp_rdata, e.is_d, e.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one request, waits (bounded) for its grant, queues the expected
    // response. Returns at the falling edge after the grant cycle.
    task automatic do_req(input bit is_d, input logic [31:0] addr, input bit wen,
                          input logic [31:0] wdata, input logic [3:0] mask,
                          output int gcyc, output int dcyc);
        @(negedge i_clk);
        if (is_d) begin
            i_d_valid = 1'b1; i_d_addr = addr; i_d_wen = wen;
            i_d_wdata = wdata; i_d_mask = mask;
        end else begin
            i_if_valid = 1'b1; i_if_addr = addr;
        end
        dcyc = cyc;
        gcyc = -1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (is_d ? o_d_ready : o_if_ready) begin
                gcyc = cyc;
                break;
            end
            @(negedge i_clk);
        end
        if (gcyc >= 0) rsp_q.push_back({is_d, (wen ? 32'h0 : mem_word(addr))});
        @(negedge i_clk);
        if (is_d) i_d_valid = 1'b0;
        else i_if_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_if_valid = 1'b1; i_if_addr = 32'h40;
        i_d_valid = 1'b1; i_d_addr = 32'h80; i_d_wen = 1'b1;
        i_d_wdata = 32'hFFFF_FFFF; i_d_mask = 4'hF;
        repeat (2) @(negedge i_clk);
        #1;
        checks++;
        if (o_if_ready !== 1'b0 || o_d_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: if_ready=%0b d_ready=%0b, required 0 0", o_if_ready, o_d_ready);
        end
        checks++;
        if (o_mem_valid !== 1'b0 || o_mem_addr !== 32'h0 || o_mem_mask !== 4'h0 || o_mem_wen !== 1'b0 ||
            o_mem_wdata !== 32'h0 || o_if_rvalid !== 1'b0 || o_d_rvalid !== 1'b0 || o_rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: mem_valid=%0b addr=%h mask=%h rsp=%h, required all 0", o_mem_valid, o_mem_addr, o_mem_mask, o_rsp_rdata);
        end
        // Release with only the fetch pending: granted at the first edge after release.
        @(negedge i_clk);
        i_d_valid = 1'b0;
        i_rst_n = 1'b1;
        #1;
        checks++;
        if (o_if_ready !== 1'b1 || o_mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: if_ready=%0b mem_valid=%0b, required 1 0", o_if_ready, o_mem_valid);
        end
        rsp_q.push_back({1'b0, mem_word(32'h40)});
        @(negedge i_clk);
        i_if_valid = 1'b0;
        #1;
        checks++;
        if (o_mem_valid !== 1'b1 || o_mem_addr !== 32'h40) begin
            errors++;
            $display("FAIL reset_first_issue: mem_valid=%0b addr=%h, required 1 00000040", o_mem_valid, o_mem_addr);
        end
        repeat (4) @(negedge i_clk);
    endtask

    task automatic test_lone_fetch();
        int g, d;
        do_req(1'b0, 32'h100, 1'b0, 32'h0, 4'hF, g, d);
        checks++;
        if (g != d) begin
            errors++;
            $display("FAIL fetch_grant_cycle: grant cycle %0d, required %0d", g, d);
        end
        #1;
        checks++;
        if (o_mem_valid !== 1'b1 || o_mem_addr !== 32'h100 || o_mem_mask !== 4'hF || o_mem_wen !== 1'b0) begin
            errors++;
            $display("FAIL fetch_issue: valid=%0b addr=%h mask=%h wen=%0b, required 1 00000100 f 0", o_mem_valid, o_mem_addr, o_mem_mask, o_mem_wen);
        end
        @(negedge i_clk); #1;
        checks++;
        if (o_mem_valid !== 1'b0 || o_if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait: mem_valid=%0b if_rvalid=%0b, required 0 0", o_mem_valid, o_if_rvalid);
        end
        @(negedge i_clk); #1;
        checks++;
        if (o_if_rvalid !== 1'b1 || o_rsp_rdata !== 32'h13 || o_d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rsp: if_rvalid=%0b data=%h d_rvalid=%0b, required 1 00000013 0", o_if_rvalid, o_rsp_rdata, o_d_rvalid);
        end
        @(negedge i_clk); #1;
        checks++;
        if (o_if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rsp_pulse: if_rvalid=%0b, required 0", o_if_rvalid);
        end
    endtask

    task automatic test_contention();
        bit          exp_d[$];
        int          n = 0;
        int          last = -1;
        logic [31:0] ia = 32'h1000;
        logic [31:0] da = 32'h3000;
        bit          was_d;
        exp_d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge i_clk);
        i_if_valid = 1'b1; i_if_addr = ia;
        i_d_valid = 1'b1; i_d_addr = da; i_d_wen = 1'b0; i_d_wdata = 32'h0; i_d_mask = 4'hF;
        for (int k = 0; k < 40 && n < 6; k++) begin
            #1;
            if (o_if_ready || o_d_ready) begin
                checks++;
                if (o_if_ready && o_d_ready) begin
                    errors++;
                    $display("FAIL contention_both_ready: both readies high at cycle %0d", cyc);
                end else if (o_d_ready !== exp_d[n]) begin
                    errors++;
                    $display("FAIL contention_order: grant %0d got d=%0b, required d=%0b", n, o_d_ready, exp_d[n]);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 3) begin
                        errors++;
                        $display("FAIL contention_spacing: grant %0d after %0d cycles, required 3", n, cyc - last);
                    end
                end
                last = cyc;
                was_d = o_d_ready;
                if (was_d) rsp_q.push_back({1'b1, mem_word(da)});
                else rsp_q.push_back({1'b0, mem_word(ia)});
                n++;
                @(negedge i_clk);
                if (was_d) begin da = da + 32'd4; i_d_addr = da; end
                else begin ia = ia + 32'd4; i_if_addr = ia; end
                if (n == 6) begin i_if_valid = 1'b0; i_d_valid = 1'b0; end
            end else begin
                @(negedge i_clk);
            end
        end
        i_if_valid = 1'b0; i_d_valid = 1'b0;
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL contention_count: %0d grants, required 6", n);
        end
        repeat (4) @(negedge i_clk);
    endtask

    task automatic test_store();
        int g, d;
        ready_delay = 4;
        do_req(1'b1, 32'h2000, 1'b1, 32'hDEAD_BEEF, 4'b1000, g, d);
        i_d_addr = 32'hFFFF_FFF0; i_d_wdata = 32'h0; i_d_mask = 4'h0; i_d_wen = 1'b0;
        checks++;
        if (g != d) begin
            errors++;
            $display("FAIL store_grant_cycle: grant cycle %0d, required %0d", g, d);
        end
        for (int k = 1; k <= 5; k++) begin
            #1;
            checks++;
            if (o_mem_valid !== 1'b1 || o_mem_addr !== 32'h2000 || o_mem_wdata !== 32'hDEAD_BEEF ||
                o_mem_mask !== 4'b1000 || o_mem_wen !== 1'b1 || o_d_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL store_hold_%0d: valid=%0b addr=%h wdata=%h mask=%h wen=%0b d_rvalid=%0b, required 1 00002000 deadbeef 8 1 0",
                         k, o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wen, o_d_rvalid);
            end
            @(negedge i_clk);
        end
        #1;
        checks++;
        if (o_d_rvalid !== 1'b1 || o_rsp_rdata !== 32'h0 || o_mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_done: d_rvalid=%0b data=%h mem_valid=%0b, required 1 00000000 0", o_d_rvalid, o_rsp_rdata, o_mem_valid);
        end
        @(negedge i_clk); #1;
        checks++;
        if (o_d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL store_done_pulse: d_rvalid=%0b, required 0", o_d_rvalid);
        end
        ready_delay = 0;
    endtask

    task automatic test_drop();
        int g, d;
        do_req(1'b0, 32'h200, 1'b0, 32'h0, 4'hF, g, d);
        i_d_valid = 1'b1; i_d_addr = 32'h7000; i_d_wen = 1'b1; i_d_wdata = 32'h1234_5678; i_d_mask = 4'hF;
        @(negedge i_clk);
        i_d_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (o_d_ready !== 1'b0 || o_mem_valid !== 1'b0) begin
                errors++;
                $display("FAIL drop_no_grant: d_ready=%0b mem_valid=%0b at cycle %0d, required 0 0", o_d_ready, o_mem_valid, cyc);
            end
            @(negedge i_clk);
        end
    endtask

    task automatic test_spurious();
        int g, d;
        do_req(1'b1, 32'h500, 1'b0, 32'h0, 4'hF, g, d);
        repeat (3) @(negedge i_clk);
        spur_data = 32'h55;
        spur_req++;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk); #1;
            checks++;
            if (o_if_rvalid !== 1'b0 || o_d_rvalid !== 1'b0 || o_rsp_rdata !== mem_word(32'h500)) begin
                errors++;
                $display("FAIL spurious_ignored: if_rvalid=%0b d_rvalid=%0b data=%h, required 0 0 %h",
                         o_if_rvalid, o_d_rvalid, o_rsp_rdata, mem_word(32'h500));
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int g, d;
        rsp_enable = 1'b0;
        do_req(1'b1, 32'h400, 1'b0, 32'h0, 4'hF, g, d);
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        i_if_valid = 1'b1; i_if_addr = 32'h900;
        #1;
        rsp_q.delete();
        checks++;
        if (o_if_ready !== 1'b0 || o_mem_valid !== 1'b0 || o_mem_addr !== 32'h0 || o_mem_mask !== 4'h0 ||
            o_if_rvalid !== 1'b0 || o_d_rvalid !== 1'b0 || o_rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wait_reset_outputs: if_ready=%0b mem_valid=%0b addr=%h mask=%h rsp=%h, required all 0",
                     o_if_ready, o_mem_valid, o_mem_addr, o_mem_mask, o_rsp_rdata);
        end
        @(negedge i_clk);
        i_if_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        rsp_enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (o_if_rvalid !== 1'b0 || o_d_rvalid !== 1'b0 || o_mem_valid !== 1'b0 || o_rsp_rdata !== 32'h0) begin
                errors++;
                $display("FAIL wait_reset_late_rvalid: if_rvalid=%0b d_rvalid=%0b mem_valid=%0b rsp=%h, required 0 0 0 0",
                         o_if_rvalid, o_d_rvalid, o_mem_valid, o_rsp_rdata);
            end
            @(negedge i_clk);
        end
    endtask

    initial begin : main
        i_rst_n = 1'b0;
        i_if_valid = 1'b0; i_if_addr = 32'h0;
        i_d_valid = 1'b0; i_d_addr = 32'h0; i_d_wen = 1'b0; i_d_wdata = 32'h0; i_d_mask = 4'h0;
        test_reset();
        test_lone_fetch();
        test_contention();
        test_store();
        test_drop();
        test_spurious();
        test_reset_in_wait();
        for (int k = 0; k < 10 && rsp_q.size() != 0; k++) @(negedge i_clk);
        #1;
        checks++;
        if (rsp_q.size() != 0) begin
            errors++;
            $display("FAIL rsp_drain: %0d responses outstanding, required 0", rsp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
